hazard_stall_unit: RTL and testbench

//  Pipeline-control counterpart to the EX/MEM bypass logic. Data hazards that bypassing

---
 rtl/hazard_stall_unit_pkg.sv | 30 +++
 rtl/hazard_stall_unit_if.sv | 32 +++
 rtl/hazard_stall_unit_sat_counter.sv | 36 +++
 rtl/hazard_stall_unit.sv | 118 +++++++++++
 tb/tb_hazard_stall_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall controller: FSM encodings, the
// hard-wired zero register, and the load-use detection helper.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_JUMP_FLUSH = 2'd1,
    ST_BR_RESOLVE = 2'd2,
    ST_BR_FLUSH   = 2'd3
  } hsu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in EX feeding an operand that ID actually reads; r0 never creates a dependency.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rw,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       use_shamt,
    input logic       use_immed
  );
    logic rs_hit;
    logic rt_hit;
    rs_hit = (ex_rw == id_rs) && !use_shamt;
    rt_hit = (ex_rw == id_rt) && !use_immed;
    return ex_mem_read && (ex_rw != REG_ZERO) && (rs_hit || rt_hit);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX hazard information in, fetch/ID-EX control and perf counters out.
// master = pipeline side that drives the hazard info, slave = the stall unit.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             UseShamt;
  logic             UseImmed;
  logic             ID_Jump;
  logic             ID_Branch;
  logic             EX_MemRead;
  logic [4:0]       EX_Rw;
  logic             EX_BranchTaken;
  logic             PCWrite;
  logic             IFWrite;
  logic             Bubble;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_Rs, ID_Rt, UseShamt, UseImmed, ID_Jump, ID_Branch,
    output EX_MemRead, EX_Rw, EX_BranchTaken,
    input  PCWrite, IFWrite, Bubble, StallCount, FlushCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, UseShamt, UseImmed, ID_Jump, ID_Branch,
    input  EX_MemRead, EX_Rw, EX_BranchTaken,
    output PCWrite, IFWrite, Bubble, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] max_s;
  logic [W-1:0] one_s;

  assign max_s = {W{1'b1}};
  assign one_s = {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (inc_i && (count_q != max_s)) begin
      count_d = count_q + one_s;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge CLK) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Resolves load-use and control hazards by freezing PC / IF-ID and injecting
// ID/EX bubbles; Mealy outputs from the registered FSM state, plus perf counters.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                CLK,
  input  logic                Reset,
  hazard_stall_unit_if.slave  hz
);

  hsu_state_e state_q;
  hsu_state_e state_d;

  logic pc_write_s;
  logic if_write_s;
  logic bubble_s;
  logic hit_s;
  logic flush_inc_s;
  logic stall_inc_s;

  logic [CNT_W-1:0] stall_count_s;
  logic [CNT_W-1:0] flush_count_s;

  assign hit_s = load_use_hit(hz.EX_MemRead, hz.EX_Rw, hz.ID_Rs, hz.ID_Rt,
                              hz.UseShamt, hz.UseImmed);

  always_comb begin
    state_d     = state_q;
    pc_write_s  = 1'b1;
    if_write_s  = 1'b1;
    bubble_s    = 1'b0;
    flush_inc_s = 1'b0;
    if (Reset) begin
      state_d    = ST_IDLE;
      pc_write_s = 1'b0;
      if_write_s = 1'b0;
      bubble_s   = 1'b1;
    end else begin
      case (state_q)
        // Load-use beats branch beats jump; a stalled branch is re-examined next cycle.
        ST_IDLE: begin
          if (hit_s) begin
            pc_write_s = 1'b0;
            if_write_s = 1'b0;
            bubble_s   = 1'b1;
          end else if (hz.ID_Branch) begin
            pc_write_s = 1'b0;
            if_write_s = 1'b0;
            state_d    = ST_BR_RESOLVE;
          end else if (hz.ID_Jump) begin
            if_write_s = 1'b0;
            state_d    = ST_JUMP_FLUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_JUMP_FLUSH: begin
          bubble_s    = 1'b1;
          flush_inc_s = 1'b1;
          state_d     = ST_IDLE;
        end
        ST_BR_RESOLVE: begin
          if_write_s = 1'b0;
          bubble_s   = 1'b1;
          if (hz.EX_BranchTaken) begin
            state_d = ST_BR_FLUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BR_FLUSH: begin
          bubble_s    = 1'b1;
          flush_inc_s = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          pc_write_s = 1'b0;
          if_write_s = 1'b0;
          bubble_s   = 1'b1;
          state_d    = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall_inc_s = !Reset && !pc_write_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .clr_i   (Reset),
    .inc_i   (stall_inc_s),
    .count_o (stall_count_s)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK     (CLK),
    .clr_i   (Reset),
    .inc_i   (flush_inc_s),
    .count_o (flush_count_s)
  );

  assign hz.PCWrite    = pc_write_s;
  assign hz.IFWrite    = if_write_s;
  assign hz.Bubble     = bubble_s;
  assign hz.StallCount = stall_count_s;
  assign hz.FlushCount = flush_count_s;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed, table-driven check of hazard_stall_unit plus hand-written
// reset-abort and counter-saturation sequences.
module tb_hazard_stall_unit;

  logic CLK;
  logic Reset;
  logic Reset2;
  int   checks;
  int   errors;

  hazard_stall_unit_if #(.CNT_W(16)) hz ();
  hazard_stall_unit_if #(.CNT_W(2))  hz2 ();

  hazard_stall_unit #(.CNT_W(16)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .hz    (hz)
  );

  hazard_stall_unit #(.CNT_W(2)) dut2 (
    .CLK   (CLK),
    .Reset (Reset2),
    .hz    (hz2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        shamt;
    logic        immed;
    logic        jump;
    logic        branch;
    logic        memread;
    logic [4:0]  rw;
    logic        taken;
    logic        pc;
    logic        ifw;
    logic        bub;
    logic [15:0] stall;
    logic [15:0] flush;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input int rs, input int rt, input int shamt, input int immed,
    input int jump, input int branch, input int memread, input int rw,
    input int taken, input int pc, input int ifw, input int bub,
    input int stall, input int flush);
    vec_t v;
    v.rs = rs[4:0];  v.rt = rt[4:0];  v.shamt = shamt[0];  v.immed = immed[0];
    v.jump = jump[0];  v.branch = branch[0];  v.memread = memread[0];
    v.rw = rw[4:0];  v.taken = taken[0];
    v.pc = pc[0];  v.ifw = ifw[0];  v.bub = bub[0];
    v.stall = stall[15:0];  v.flush = flush[15:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.ID_Rs = v.rs;  hz.ID_Rt = v.rt;  hz.UseShamt = v.shamt;  hz.UseImmed = v.immed;
    hz.ID_Jump = v.jump;  hz.ID_Branch = v.branch;  hz.EX_MemRead = v.memread;
    hz.EX_Rw = v.rw;  hz.EX_BranchTaken = v.taken;
  endtask

  task automatic check_ctl(input string tag, input logic pc, input logic ifw, input logic bub,
                           input logic [15:0] st, input logic [15:0] fl);
    check({tag, ".PCWrite"},    {31'd0, hz.PCWrite}, {31'd0, pc});
    check({tag, ".IFWrite"},    {31'd0, hz.IFWrite}, {31'd0, ifw});
    check({tag, ".Bubble"},     {31'd0, hz.Bubble},  {31'd0, bub});
    check({tag, ".StallCount"}, {16'd0, hz.StallCount}, {16'd0, st});
    check({tag, ".FlushCount"}, {16'd0, hz.FlushCount}, {16'd0, fl});
  endtask

  vec_t z;

  initial begin
    checks = 0;
    errors = 0;
    z = mk(0,0,0,0,0,0,0,0,0, 0,0,0, 0,0);

    //        rs rt sh im j  b  mr rw tk  pc if bu  st fl
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 1,  0, 0));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 5, 0,  1, 1, 0,  1, 0));
    vecs.push_back(mk(5, 7, 1, 0, 0, 0, 1, 5, 0,  1, 1, 0,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0,  1, 0));
    vecs.push_back(mk(3, 7, 0, 1, 0, 0, 1, 7, 0,  1, 1, 0,  1, 0));
    vecs.push_back(mk(3, 7, 0, 0, 0, 0, 1, 7, 0,  0, 0, 1,  1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0,  2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 1, 1,  2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0,  2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1,  1, 0, 1,  3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1,  3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0,  3, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1,  4, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  4, 2));
    vecs.push_back(mk(5, 0, 0, 0, 0, 1, 1, 5, 0,  0, 0, 1,  4, 2));
    vecs.push_back(mk(5, 0, 0, 0, 0, 1, 0, 5, 0,  0, 0, 0,  5, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1,  6, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1,  6, 2));
    vecs.push_back(mk(0, 9, 0, 0, 1, 0, 1, 9, 0,  0, 0, 1,  6, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  7, 3));

    // Reset held for two cycles; the second DUT stays in reset until its own test.
    Reset  = 1'b1;
    Reset2 = 1'b1;
    drive(z);
    hz2.ID_Rs = 5'd0;  hz2.ID_Rt = 5'd0;  hz2.UseShamt = 1'b0;  hz2.UseImmed = 1'b0;
    hz2.ID_Jump = 1'b0;  hz2.ID_Branch = 1'b0;  hz2.EX_MemRead = 1'b0;
    hz2.EX_Rw = 5'd0;  hz2.EX_BranchTaken = 1'b0;
    @(negedge CLK);
    check("rst_c1.PCWrite", {31'd0, hz.PCWrite}, 32'd0);
    check("rst_c1.IFWrite", {31'd0, hz.IFWrite}, 32'd0);
    check("rst_c1.Bubble",  {31'd0, hz.Bubble},  32'd1);
    @(negedge CLK);
    check_ctl("rst_c2", 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);

    Reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check_ctl($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifw, vecs[i].bub,
                vecs[i].stall, vecs[i].flush);
      @(negedge CLK);
    end

    // Branch, then reset while in BR_RESOLVE: must land in IDLE with counters cleared.
    drive(mk(0,0,0,0,0,1,0,0,0, 0,0,0, 0,0));
    #1;
    check_ctl("abort_br", 1'b0, 1'b0, 1'b0, 16'd7, 16'd3);
    @(negedge CLK);
    Reset = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,1, 0,0,0, 0,0));
    #1;
    check_ctl("abort_rst", 1'b0, 1'b0, 1'b1, 16'd8, 16'd3);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check_ctl("abort_idle", 1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    @(negedge CLK);
    drive(z);
    #1;
    check_ctl("abort_after", 1'b1, 1'b1, 1'b0, 16'd0, 16'd0);

    // Narrow counter: continuous load-use stall must stick at 3.
    @(negedge CLK);
    Reset2 = 1'b0;
    hz2.EX_MemRead = 1'b1;  hz2.EX_Rw = 5'd4;  hz2.ID_Rs = 5'd4;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("sat_c%0d.PCWrite", c), {31'd0, hz2.PCWrite}, 32'd0);
      check($sformatf("sat_c%0d.StallCount", c), {30'd0, hz2.StallCount},
            (c < 3) ? c : 32'd3);
      @(negedge CLK);
    end
    hz2.EX_MemRead = 1'b0;
    #1;
    check("sat_hold.StallCount", {30'd0, hz2.StallCount}, 32'd3);
    check("sat_hold.PCWrite",    {31'd0, hz2.PCWrite},    32'd1);
    check("sat_hold.FlushCount", {30'd0, hz2.FlushCount}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
